// File: rtl/sgp_pkg.sv
// Shared definitions for the LSB extractor: lsb_sel encodings, FSM states
// and the per-setting bit count / pixels-per-byte / mask lookup.
package sgp_pkg;

    typedef enum logic [1:0] {
        LSB_1   = 2'd0,
        LSB_2   = 2'd1,
        LSB_4   = 2'd2,
        LSB_RSV = 2'd3
    } lsb_sel_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        PUSH    = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] bits;   // k, bits taken from each pixel
        logic [3:0] ppb;    // pixels per secret byte, 8/k
        logic [7:0] mask;   // low-k-bit mask applied to each pixel
    } lsb_cfg_t;

    // The reserved encoding behaves exactly like one bit per pixel.
    function automatic lsb_cfg_t lsb_cfg(input logic [1:0] sel);
        lsb_cfg_t cfg;
        case (sel)
            LSB_2:   cfg = '{bits: 3'd2, ppb: 4'd4, mask: 8'h03};
            LSB_4:   cfg = '{bits: 3'd4, ppb: 4'd2, mask: 8'h0F};
            default: cfg = '{bits: 3'd1, ppb: 4'd8, mask: 8'h01};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/sgp_extract_if.sv
// FIFO-side bundle of the extractor: image FIFO read port and output FIFO
// write port. master = extractor, slave = FIFO wrapper.
interface sgp_extract_if #(
    parameter int FF_WIDTH = 8
) ();

    logic                ff_image_empty;
    logic [FF_WIDTH-1:0] ff_rdimage;
    logic                ff_image_rden;
    logic                ff_out_full;
    logic [FF_WIDTH-1:0] ff_out_wrdata;
    logic                ff_out_wren;

    modport master (
        input  ff_image_empty,
        input  ff_rdimage,
        input  ff_out_full,
        output ff_image_rden,
        output ff_out_wrdata,
        output ff_out_wren
    );

    modport slave (
        output ff_image_empty,
        output ff_rdimage,
        output ff_out_full,
        input  ff_image_rden,
        input  ff_out_wrdata,
        input  ff_out_wren
    );

endinterface

// File: rtl/sgp_bit_packer.sv
// Shift register plus pixel counter: appends the low k bits of each loaded
// pixel so the first pixel of a byte ends up in the MSBs.
module sgp_bit_packer
    import sgp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [1:0]   k,
    input  logic [W-1:0] pixel,
    output logic [W-1:0] byte_out,
    output logic         byte_done
);

    lsb_cfg_t     cfg;
    logic [W-1:0] mask_ext;
    logic [W-1:0] pix_masked;
    logic [W-1:0] shift_reg;
    logic [W-1:0] shift_next;
    logic [3:0]   cnt_reg;
    logic [3:0]   cnt_next;

    assign cfg      = lsb_cfg(k);
    assign mask_ext = W'(cfg.mask);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_mask
            assign pix_masked[gi] = pixel[gi] & mask_ext[gi];
        end
    endgenerate

    assign shift_next = (shift_reg << cfg.bits) | pix_masked;

    // High while the counter sits on the last pixel slot: the next load
    // completes the byte.
    assign byte_done = (cnt_reg == (cfg.ppb - 4'd1));
    assign cnt_next  = byte_done ? 4'd0 : cnt_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign byte_out = shift_reg;

endmodule

// File: rtl/sgp_extract.sv
// LSB extractor: pops stego pixels, packs their k low bits MSB-first into
// secret bytes and pushes msg_size bytes into the output FIFO.
module sgp_extract
    import sgp_pkg::*;
#(
    parameter int FF_WIDTH  = 8,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           lsb_sel,
    input  logic [REG_WIDTH-1:0] msg_size,
    sgp_extract_if.master        fifo,
    output logic                 busy,
    output logic                 finish,
    output logic [REG_WIDTH-1:0] byte_count
);

    state_t               state_reg;
    logic                 start_d_reg;
    logic [1:0]           k_reg;
    logic [REG_WIDTH-1:0] size_reg;
    logic [REG_WIDTH-1:0] count_reg;
    logic [REG_WIDTH-1:0] count_next;
    logic                 rden_reg;
    logic                 wren_reg;
    logic [FF_WIDTH-1:0]  wrdata_reg;
    logic                 busy_reg;
    logic                 finish_reg;

    logic                 launch;
    logic                 pack_clr;
    logic                 pack_load;
    logic [FF_WIDTH-1:0]  pack_byte;
    logic                 pack_last;

    assign launch     = start & ~start_d_reg;
    assign count_next = count_reg + REG_WIDTH'(1);
    assign pack_clr   = (state_reg == IDLE) && launch;
    assign pack_load  = (state_reg == CAPTURE);

    sgp_bit_packer #(
        .W (FF_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr),
        .load      (pack_load),
        .k         (k_reg),
        .pixel     (fifo.ff_rdimage),
        .byte_out  (pack_byte),
        .byte_done (pack_last)
    );

    // rden is registered one edge ahead: the pop request is armed on the edge
    // entering FETCH (when the FIFO is seen non-empty) so the pop itself lands
    // on the edge leaving FETCH and the data is valid during CAPTURE. Only
    // this block pops, so a non-empty FIFO cannot drain underneath the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            start_d_reg <= 1'b0;
            k_reg       <= LSB_1;
            size_reg    <= '0;
            count_reg   <= '0;
            rden_reg    <= 1'b0;
            wren_reg    <= 1'b0;
            wrdata_reg  <= '0;
            busy_reg    <= 1'b0;
            finish_reg  <= 1'b0;
        end else begin
            start_d_reg <= start;
            rden_reg    <= 1'b0;
            wren_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    finish_reg <= 1'b0;
                    if (launch) begin
                        k_reg     <= lsb_sel;
                        size_reg  <= msg_size;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        if (msg_size == '0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= FETCH;
                            rden_reg  <= ~fifo.ff_image_empty;
                        end
                    end
                end
                FETCH: begin
                    if (rden_reg) begin
                        state_reg <= CAPTURE;
                    end else begin
                        rden_reg <= ~fifo.ff_image_empty;
                    end
                end
                CAPTURE: begin
                    if (pack_last) begin
                        state_reg <= PUSH;
                    end else begin
                        state_reg <= FETCH;
                        rden_reg  <= ~fifo.ff_image_empty;
                    end
                end
                PUSH: begin
                    if (!fifo.ff_out_full) begin
                        wren_reg   <= 1'b1;
                        wrdata_reg <= pack_byte;
                        count_reg  <= count_next;
                        if (count_next == size_reg) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= FETCH;
                            rden_reg  <= ~fifo.ff_image_empty;
                        end
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    // finish is shown for at least one cycle even if start
                    // has already dropped, then held until start is low.
                    if (!finish_reg) begin
                        finish_reg <= 1'b1;
                    end else if (!start) begin
                        finish_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fifo.ff_image_rden = rden_reg;
    assign fifo.ff_out_wren   = wren_reg;
    assign fifo.ff_out_wrdata = wrdata_reg;
    assign busy               = busy_reg;
    assign finish             = finish_reg;
    assign byte_count         = count_reg;

endmodule

// File: tb/tb_sgp_extract.sv
// Directed bench for sgp_extract: FIFO models on both sides, hand-computed
// secret bytes, timing and stall/reset scenarios.
module tb_sgp_extract;
    import sgp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  lsb_sel;
    logic [31:0] msg_size;
    logic        busy;
    logic        finish;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    sgp_extract_if #(.FF_WIDTH(8)) fifo ();

    sgp_extract #(
        .FF_WIDTH  (8),
        .REG_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lsb_sel    (lsb_sel),
        .msg_size   (msg_size),
        .fifo       (fifo),
        .busy       (busy),
        .finish     (finish),
        .byte_count (byte_count)
    );

    // Image FIFO model (stimulus writes, DUT pops) and output FIFO capture.
    logic [7:0] img_mem [0:127];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    logic [7:0] rd_data   = 8'h00;
    int         rd_cnt    = 0;
    int         underflow = 0;
    logic [7:0] out_mem [0:31];
    int         out_cnt   = 0;
    int         overflow  = 0;
    logic       out_full  = 1'b0;

    assign fifo.ff_image_empty = (rd_ptr == wr_ptr);
    assign fifo.ff_rdimage     = rd_data;
    assign fifo.ff_out_full    = out_full;

    always @(posedge clk) begin
        if (fifo.ff_image_rden) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_ptr == wr_ptr) begin
                underflow <= underflow + 1;
            end else begin
                rd_data <= img_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1;
            end
        end
        if (fifo.ff_out_wren) begin
            if (out_full) overflow <= overflow + 1;
            out_mem[out_cnt] <= fifo.ff_out_wrdata;
            out_cnt          <= out_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int base_out;
    int base_rd;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("[%0t] check %s obs=0x%0h exp=0x%0h", $time, tag, obs, exp);
        end else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic push_pix(input logic [7:0] p);
        img_mem[wr_ptr] = p;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_finish(input string tag, input int budget);
        int cyc = 0;
        while (finish !== 1'b1 && cyc < budget) begin
            tick(1);
            cyc++;
        end
        chk({tag, "_finish"}, {31'd0, finish}, 32'd1);
    endtask

    task automatic end_run(input string tag);
        start = 1'b0;
        tick(1);
        chk({tag, "_finish_drop"}, {31'd0, finish}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic mark();
        base_out = out_cnt;
        base_rd  = rd_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        lsb_sel  = LSB_1;
        msg_size = 32'd0;
        tick(3);

        // Reset state
        chk("rst_rden",   {31'd0, fifo.ff_image_rden}, 32'd0);
        chk("rst_wren",   {31'd0, fifo.ff_out_wren}, 32'd0);
        chk("rst_wrdata", {24'd0, fifo.ff_out_wrdata}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_finish", {31'd0, finish}, 32'd0);
        chk("rst_count",  byte_count, 32'd0);
        rst = 1'b0;
        tick(2);

        // k=1, one byte: LSBs 1,0,1,0,0,1,0,1 -> 0xA5, pushed 17 cycles after first FETCH
        mark();
        lsb_sel  = LSB_1;
        msg_size = 32'd1;
        push_pix(8'h11); push_pix(8'h10); push_pix(8'h33); push_pix(8'h42);
        push_pix(8'hFE); push_pix(8'h01); push_pix(8'h80); push_pix(8'h7F);
        start = 1'b1;
        n = 0;
        while (fifo.ff_out_wren !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk("k1_latency", n, 32'd18);
        chk("k1_wrdata_at_wren", {24'd0, fifo.ff_out_wrdata}, 32'hA5);
        wait_finish("k1", 40);
        chk("k1_byte",   {24'd0, out_mem[base_out]}, 32'hA5);
        chk("k1_pushes", out_cnt - base_out, 32'd1);
        chk("k1_count",  byte_count, 32'd1);
        chk("k1_rden",   rd_cnt - base_rd, 32'd8);
        end_run("k1");

        // k=2, two bytes: 00 11 11 00 -> 0x3C twice
        mark();
        lsb_sel  = LSB_2;
        msg_size = 32'd2;
        for (int r = 0; r < 2; r++) begin
            push_pix(8'h40); push_pix(8'h13); push_pix(8'hFF); push_pix(8'h04);
        end
        start = 1'b1;
        wait_finish("k2", 80);
        chk("k2_byte0",  {24'd0, out_mem[base_out]}, 32'h3C);
        chk("k2_byte1",  {24'd0, out_mem[base_out+1]}, 32'h3C);
        chk("k2_pushes", out_cnt - base_out, 32'd2);
        chk("k2_count",  byte_count, 32'd2);
        chk("k2_rden",   rd_cnt - base_rd, 32'd8);
        end_run("k2");

        // k=4: 0xD, 0x7 -> 0xD7
        mark();
        lsb_sel  = LSB_4;
        msg_size = 32'd1;
        push_pix(8'h0D); push_pix(8'hF7);
        start = 1'b1;
        wait_finish("k4", 30);
        chk("k4_byte",   {24'd0, out_mem[base_out]}, 32'hD7);
        chk("k4_pushes", out_cnt - base_out, 32'd1);
        chk("k4_rden",   rd_cnt - base_rd, 32'd2);
        end_run("k4");

        // Reserved lsb_sel behaves as k=1, with an image-FIFO stall after 3 pixels
        mark();
        lsb_sel  = LSB_RSV;
        msg_size = 32'd1;
        push_pix(8'h11); push_pix(8'h10); push_pix(8'h33);
        start = 1'b1;
        tick(8);
        chk("stall_rden_before", rd_cnt - base_rd, 32'd3);
        tick(5);
        chk("stall_rden_during", rd_cnt - base_rd, 32'd3);
        chk("stall_rden_low",    {31'd0, fifo.ff_image_rden}, 32'd0);
        chk("stall_busy",        {31'd0, busy}, 32'd1);
        push_pix(8'h42); push_pix(8'hFE); push_pix(8'h01); push_pix(8'h80); push_pix(8'h7F);
        wait_finish("stall", 40);
        chk("stall_byte",   {24'd0, out_mem[base_out]}, 32'hA5);
        chk("stall_pushes", out_cnt - base_out, 32'd1);
        chk("stall_rden",   rd_cnt - base_rd, 32'd8);
        end_run("stall");

        // Output FIFO full for 10 cycles at PUSH
        mark();
        lsb_sel  = LSB_4;
        msg_size = 32'd1;
        push_pix(8'h0D); push_pix(8'hF7);
        out_full = 1'b1;
        start = 1'b1;
        tick(10);
        chk("full_no_push", out_cnt - base_out, 32'd0);
        chk("full_wren",    {31'd0, fifo.ff_out_wren}, 32'd0);
        chk("full_wrdata",  {24'd0, fifo.ff_out_wrdata}, 32'hA5);
        chk("full_busy",    {31'd0, busy}, 32'd1);
        out_full = 1'b0;
        wait_finish("full", 20);
        chk("full_byte",   {24'd0, out_mem[base_out]}, 32'hD7);
        chk("full_pushes", out_cnt - base_out, 32'd1);
        end_run("full");

        // msg_size = 0: finish two cycles after start, no traffic
        mark();
        msg_size = 32'd0;
        start = 1'b1;
        tick(1);
        chk("zero_finish_c1", {31'd0, finish}, 32'd0);
        tick(1);
        chk("zero_finish_c2", {31'd0, finish}, 32'd1);
        chk("zero_count",     byte_count, 32'd0);
        chk("zero_rden",      rd_cnt - base_rd, 32'd0);
        chk("zero_pushes",    out_cnt - base_out, 32'd0);
        end_run("zero");

        // Reset after 3 pixels of a byte
        mark();
        lsb_sel  = LSB_1;
        msg_size = 32'd1;
        for (int i = 0; i < 8; i++) push_pix(8'hFF);
        start = 1'b1;
        tick(6);
        rst   = 1'b1;
        start = 1'b0;
        tick(1);
        chk("mrst_rden",   {31'd0, fifo.ff_image_rden}, 32'd0);
        chk("mrst_wren",   {31'd0, fifo.ff_out_wren}, 32'd0);
        chk("mrst_wrdata", {24'd0, fifo.ff_out_wrdata}, 32'd0);
        chk("mrst_busy",   {31'd0, busy}, 32'd0);
        chk("mrst_finish", {31'd0, finish}, 32'd0);
        chk("mrst_count",  byte_count, 32'd0);
        chk("mrst_pushes", out_cnt - base_out, 32'd0);
        rst = 1'b0;
        wr_ptr = rd_ptr;
        tick(2);

        // Re-launch with fresh pixels -> 0x5A; start re-edge and setting changes mid-run ignored
        mark();
        push_pix(8'h00); push_pix(8'h01); push_pix(8'h00); push_pix(8'h01);
        push_pix(8'h01); push_pix(8'h00); push_pix(8'h01); push_pix(8'h00);
        start = 1'b1;
        tick(4);
        start    = 1'b0;
        msg_size = 32'd5;
        lsb_sel  = LSB_4;
        tick(1);
        start = 1'b1;
        wait_finish("relaunch", 40);
        chk("relaunch_byte",   {24'd0, out_mem[base_out]}, 32'h5A);
        chk("relaunch_pushes", out_cnt - base_out, 32'd1);
        chk("relaunch_count",  byte_count, 32'd1);
        chk("relaunch_rden",   rd_cnt - base_rd, 32'd8);
        end_run("relaunch");

        chk("no_underflow", underflow, 32'd0);
        chk("no_overflow",  overflow, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sgp_extract.md
Name: sgp_extract

Overview:
- Decode-side counterpart of the LSB embedder.
- Pops stego-image pixel bytes from the image FIFO, extracts the k least-significant bits of each pixel, and packs them MSB-first into secret bytes.
- Pushes each completed secret byte into the output FIFO, which the BRAM writer drains to the secret BRAM.
- Stops after msg_size bytes and reports completion to the control unit.

Parameters:
- FF_WIDTH, 8, FIFO data width (pixel/secret byte).
- REG_WIDTH, 32, width of size and counter registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level from control register; a rising edge launches one extraction.
- lsb_sel  in  2  bits per pixel: 0=1, 1=2, 2=4, 3=reserved (treated as 1).
- msg_size  in  REG_WIDTH  number of secret bytes to extract.
- ff_image_empty  in  1  image FIFO empty.
- ff_rdimage  in  FF_WIDTH  image FIFO read data, valid the cycle after rden.
- ff_image_rden  out  1  image FIFO pop.
- ff_out_full  in  1  output FIFO full.
- ff_out_wrdata  out  FF_WIDTH  extracted secret byte.
- ff_out_wren  out  1  output FIFO push.
- busy  out  1  extraction in progress.
- finish  out  1  all msg_size bytes pushed.
- byte_count  out  REG_WIDTH  bytes pushed so far (debug).

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. All outputs 0: rden, wren, wrdata, busy, finish, byte_count. Internal shift register, pixel counter and start_d are cleared. Reset wins over every simultaneous event and aborts any operation in progress; partial bytes are discarded.
- Start detection: start_d is start registered; launch = start & ~start_d. On launch in IDLE, latch msg_size and lsb_sel (k), clear byte_count, assert busy. Launch outside IDLE is ignored. Mid-run changes to lsb_sel or msg_size have no effect.
- Pixels per byte: P = 8/k, i.e. 8, 4 or 2. The pixel counter runs 0..P-1.
- State IDLE -> on launch: to DONE if latched msg_size==0, otherwise to FETCH.
- State FETCH:
  - if !ff_image_empty: assert ff_image_rden for exactly one cycle and go to CAPTURE.
  - otherwise stay in FETCH with rden=0; never pop an empty FIFO.
- State CAPTURE: ff_rdimage is valid this cycle. Update shift = (shift << k) | (ff_rdimage & mask_k).
  - if pixel counter == P-1: clear the counter and go to PUSH.
  - otherwise increment the counter and go to FETCH.
- Bit order: the first pixel's bits land in the MSBs of the byte.
- State PUSH:
  - if !ff_out_full: ff_out_wren=1 for one cycle, ff_out_wrdata=shift, byte_count+1. Then go to DONE if byte_count+1 == msg_size, otherwise to FETCH.
  - if full: hold wren=0 and keep shift stable until space is available.
- State DONE: busy=0, finish=1. finish holds until start is deasserted, then the block returns to IDLE with finish=0.
- Throughput: 2 cycles per pixel plus 1 cycle per byte, with no stalls. With k=1, a byte is pushed 17 cycles after the first FETCH cycle in which the FIFO is non-empty.
- Pixels remaining in the image FIFO after completion are not consumed.
- Outputs are registered; ff_out_wrdata is stable while ff_out_wren=1.
- Arithmetic: byte_count compare is unsigned REG_WIDTH; there is no wrap because msg_size bounds it.

Decomposition:
- Shared package sgp_pkg holds:
  - lsb_sel encodings (LSB_1=0, LSB_2=1, LSB_4=2);
  - FSM state encoding (IDLE, FETCH, CAPTURE, PUSH, DONE);
  - the mask_k and P lookup function.
- One natural sub-module, sgp_bit_packer: the shift register plus pixel counter. Inputs: clk, rst, clr, load, k, pixel. Outputs: byte_out, byte_done. The FSM and counters remain in sgp_extract.

Test Plan:
- k=1, msg_size=1, FIFO holds 0x11,0x10,0x33,0x42,0xFE,0x01,0x80,0x7F -> exactly one push of 0xA5; finish=1, byte_count=1; 8 rden pulses.
- k=2, msg_size=2, pixels 0x40,0x13,0xFF,0x04,0x40,0x13,0xFF,0x04 -> pushes 0x3C, 0x3C; finish after the second push.
- k=4, msg_size=1, pixels 0x0D,0xF7 -> push 0xD7. lsb_sel=3 with the same 8 pixels as scenario 1 -> 0xA5.
- Stall handling:
  - hold ff_image_empty=1 for 5 cycles mid-byte: no rden while empty, result unchanged;
  - hold ff_out_full=1 for 10 cycles at PUSH: wren stays 0, wrdata stable, push occurs when full clears.
- msg_size=0 launch: finish=1 two cycles after start rises, no rden and no wren. Deassert start: finish drops next cycle.
- Reset and re-launch:
  - rst pulse mid-byte (after 3 pixels): all outputs 0, IDLE;
  - new start edge with fresh pixels gives a correct byte with no leftover bits;
  - a start edge while busy is ignored.
